// File: rtl/pixel_pkg.sv
// Shared constants, reader state encoding and address packing for the pixel
// memory read path.
package pixel_pkg;

    localparam int PIX_N      = 32;
    localparam int PIX_WIDTH  = 350;
    localparam int PIX_HEIGHT = 270;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        FLUSH
    } reader_state_t;

    // j lives in the upper half of the address, i in the lower half.
    function automatic logic [PIX_N-1:0] pack_ij(input logic [PIX_N/2-1:0] j,
                                                 input logic [PIX_N/2-1:0] i);
        return {j, i};
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs captured 1-bit pixels MSB-first into bytes and holds them in a
// single valid/ready output slot.
module pixel_packer
    import pixel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture,
    input  logic       pix,
    input  logic       flush,
    output logic [3:0] fill,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last
);

    logic [7:0] sr_bits;
    logic [3:0] fill_reg;
    logic       load;

    assign fill = fill_reg;

    // A full byte, or any leftover pixels once the scan has finished, moves
    // into the slot when it is empty or being emptied this cycle.
    assign load = ((fill_reg == 4'd8) || (flush && (fill_reg != 4'd0)))
                  && (!m_valid || m_ready);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            logic bit_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bit_reg <= 1'b0;
                end else if (load) begin
                    bit_reg <= 1'b0;
                end else if (capture && (fill_reg[2:0] == 3'(7 - gi))) begin
                    bit_reg <= pix;
                end
            end
            assign sr_bits[gi] = bit_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg <= 4'd0;
            m_data   <= 8'd0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else if (load) begin
            m_data   <= sr_bits;
            m_valid  <= 1'b1;
            m_last   <= flush;
            fill_reg <= 4'd0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (capture) begin
                fill_reg <= fill_reg + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pixel_frame_reader.sv
// Read-side master for the 1-bit pixel memory: scans one frame in raster
// order and streams the pixels packed 8 per byte on a valid/ready port.
module pixel_frame_reader
    import pixel_pkg::*;
#(
    parameter int N      = PIX_N,
    parameter int WIDTH  = PIX_WIDTH,
    parameter int HEIGHT = PIX_HEIGHT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] mem_addr_ij,
    output logic         mem_wr,
    input  logic [N-1:0] mem_data_out,
    output logic [7:0]   m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last
);

    localparam int HALF = N / 2;

    reader_state_t   state_reg;
    logic [HALF-1:0] i_reg;
    logic [HALF-1:0] j_reg;
    logic            inflight_reg;
    logic [3:0]      fill;
    logic            issue;
    logic            flush;
    logic            last_hs;
    logic            unused_mem_bits;

    assign mem_wr          = 1'b0;
    assign unused_mem_bits = ^mem_data_out[N-1:1];
    assign flush           = (state_reg == FLUSH);
    assign last_hs         = m_valid && m_ready && m_last;

    // Never let captured plus outstanding pixels exceed one byte.
    assign issue = (state_reg == SCAN)
                   && (({1'b0, fill} + {4'b0000, inflight_reg}) < 5'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            j_reg        <= '0;
            inflight_reg <= 1'b0;
            mem_addr_ij  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            inflight_reg <= issue;
            case (state_reg)
                IDLE: begin
                    // A start coinciding with done belongs to the old frame.
                    if (start && !done) begin
                        state_reg <= SCAN;
                        busy      <= 1'b1;
                        i_reg     <= '0;
                        j_reg     <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        mem_addr_ij <= pack_ij(j_reg, i_reg);
                        if (i_reg == HALF'(WIDTH - 1)) begin
                            i_reg <= '0;
                            if (j_reg == HALF'(HEIGHT - 1)) begin
                                state_reg <= DRAIN;
                            end else begin
                                j_reg <= j_reg + 1'b1;
                            end
                        end else begin
                            i_reg <= i_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last issued pixel is always captured on this edge.
                    state_reg <= FLUSH;
                end
                FLUSH: begin
                    if (last_hs) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    pixel_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (inflight_reg),
        .pix     (mem_data_out[0]),
        .flush   (flush),
        .fill    (fill),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Scoreboard bench: a frame model predicts bytes and addresses, monitors
// compare them against two reader instances of different geometry.
module tb_pixel_frame_reader;

    localparam int N  = 32;
    localparam int WA = 12;
    localparam int HA = 3;
    localparam int PA = WA * HA;
    localparam int WB = 8;
    localparam int HB = 1;
    localparam int PB = WB * HB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start_a = 1'b0, m_ready_a = 1'b1;
    logic         busy_a, done_a, mem_wr_a, m_valid_a, m_last_a;
    logic [N-1:0] addr_a, rdata_a;
    logic [7:0]   m_data_a;

    logic         start_b = 1'b0, m_ready_b = 1'b1;
    logic         busy_b, done_b, mem_wr_b, m_valid_b, m_last_b;
    logic [N-1:0] addr_b, rdata_b;
    logic [7:0]   m_data_b;

    bit pix_a [PA];
    bit pix_b [PB];

    int n_checks = 0;
    int n_pass = 0;
    int wr_bad = 0;
    int done_cnt_a = 0;
    int frames_a = 0;
    int bytes_b = 0;

    logic [8:0]  exp_a[$];
    logic [8:0]  exp_b[$];
    logic [31:0] addr_q[$];

    pixel_frame_reader #(.N(N), .WIDTH(WA), .HEIGHT(HA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_addr_ij(addr_a), .mem_wr(mem_wr_a), .mem_data_out(rdata_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a)
    );

    pixel_frame_reader #(.N(N), .WIDTH(WB), .HEIGHT(HB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr_ij(addr_b), .mem_wr(mem_wr_b), .mem_data_out(rdata_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b)
    );

    // Memories answer combinationally from the registered address.
    always_comb begin
        rdata_a = '0;
        if (addr_a[15:0] < 16'(WA) && addr_a[31:16] < 16'(HA))
            rdata_a[0] = pix_a[int'(addr_a[31:16]) * WA + int'(addr_a[15:0])];
        rdata_b = '0;
        if (addr_b[15:0] < 16'(WB) && addr_b[31:16] < 16'(HB))
            rdata_b[0] = pix_b[int'(addr_b[31:16]) * WB + int'(addr_b[15:0])];
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endfunction

    // Reference: pixel p = j*W+i goes to byte p/8, bit 7-(p%8); tail bits zero.
    task automatic build_a(input int mode);
        int nbytes;
        logic [7:0] v;
        for (int j = 0; j < HA; j++)
            for (int i = 0; i < WA; i++) begin
                pix_a[j * WA + i] = (mode == 1) ? bit'((i + j) & 1) : bit'($urandom_range(1));
                addr_q.push_back({16'(j), 16'(i)});
            end
        nbytes = (PA + 7) / 8;
        for (int b = 0; b < nbytes; b++) begin
            v = 8'h00;
            for (int k = 0; k < 8; k++)
                if (b * 8 + k < PA) v[7 - k] = pix_a[b * 8 + k];
            exp_a.push_back({(b == nbytes - 1) ? 1'b1 : 1'b0, v});
        end
    endtask

    logic        hold_a = 1'b0, hs_last_a = 1'b0, hs_last_b = 1'b0;
    logic [8:0]  held_a;
    logic [31:0] prev_addr_a = '0;
    logic [8:0]  e;

    always @(negedge clk) begin
        if (mem_wr_a || mem_wr_b) wr_bad++;
        if (!rst_n) begin
            hold_a = 1'b0;
            hs_last_a = 1'b0;
            hs_last_b = 1'b0;
            prev_addr_a = '0;
        end else begin
            if (hold_a) begin
                check("hold_valid", m_valid_a, 1);
                check("hold_data", {m_last_a, m_data_a}, held_a);
            end
            if (hs_last_a) begin
                check("done_after_last_a", done_a, 1);
                check("busy_at_done_a", busy_a, 0);
                hs_last_a = 1'b0;
            end
            if (done_a) done_cnt_a++;
            if (addr_a != prev_addr_a) begin
                check("addr_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check("addr_order", addr_a, addr_q.pop_front());
                prev_addr_a = addr_a;
            end
            if (m_valid_a && m_ready_a) begin
                $display("A byte data=%02h last=%0b", m_data_a, m_last_a);
                check("byte_expected_a", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    check("byte_a", {m_last_a, m_data_a}, e);
                end
                if (m_last_a) hs_last_a = 1'b1;
            end
            hold_a = m_valid_a && !m_ready_a;
            held_a = {m_last_a, m_data_a};

            if (hs_last_b) begin
                check("done_after_last_b", done_b, 1);
                hs_last_b = 1'b0;
            end
            if (m_valid_b && m_ready_b) begin
                $display("B byte data=%02h last=%0b", m_data_b, m_last_b);
                bytes_b++;
                check("byte_expected_b", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    e = exp_b.pop_front();
                    check("byte_b", {m_last_b, m_data_b}, e);
                end
                if (m_last_b) hs_last_b = 1'b1;
            end
        end
    end

    task automatic run_a(input int mode, input int ready_pct, input bit poke);
        bit got;
        build_a(mode);
        if (addr_a == '0) void'(addr_q.pop_front());
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            m_ready_a = ($urandom_range(99) < ready_pct);
            start_a = poke && (c % 37 == 5);
            @(negedge clk);
            if (done_a) begin
                got = 1'b1;
                start_a = poke;
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        m_ready_a = 1'b1;
        check("frame_done_a", got, 1);
        if (got) frames_a++;
        repeat (30) @(posedge clk);
        #1;
        check("bytes_left_a", exp_a.size(), 0);
        check("addrs_left_a", addr_q.size(), 0);
        check("idle_busy_a", busy_a, 0);
        exp_a.delete();
        addr_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", m_valid_a, 0);
        check("rst_last", m_last_a, 0);
        check("rst_data", m_data_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_valid_b", m_valid_b, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        run_a(0, 100, 1'b0);
        run_a(1, 100, 1'b0);
        run_a(1, 30, 1'b0);
        run_a(0, 50, 1'b1);

        // Reset in the middle of a scan discards the partial frame.
        build_a(0);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        m_ready_a = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", m_valid_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_addr", addr_a, 0);
        exp_a.delete();
        addr_q.delete();
        m_ready_a = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        run_a(0, 70, 1'b0);

        // Exact multiple of 8 pixels: a single last byte, no padding byte.
        for (int p = 0; p < PB; p++) pix_b[p] = bit'($urandom_range(1));
        begin
            logic [7:0] v;
            for (int k = 0; k < 8; k++) v[7 - k] = pix_b[k];
            exp_b.push_back({1'b1, v});
        end
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        begin
            bit got_b = 1'b0;
            for (int c = 0; c < 500 && !got_b; c++) begin
                @(negedge clk);
                if (done_b) got_b = 1'b1;
            end
            check("frame_done_b", got_b, 1);
        end
        repeat (20) @(posedge clk);
        #1;
        check("bytes_b", bytes_b, 1);
        check("bytes_left_b", exp_b.size(), 0);

        check("mem_wr_low", wr_bad, 0);
        check("done_pulses_a", done_cnt_a, frames_a);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
